// File: rtl/alu_pkg.sv
// Shared types for the serial ALU: command encoding, FSM states and a helper
// for sizing the slice index counter.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        XOR = 2'b10,
        SHR = 2'b11
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } alu_state_t;

    // Width of a counter that walks 0..nsl-1, never narrower than one bit.
    function automatic int idx_width(input int nsl);
        return (nsl > 1) ? $clog2(nsl) : 1;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One SLICE-bit step of the serial ALU. Purely combinational: the top feeds it
// one slice of each operand per clock and registers the carry between steps.
// For SHR the slice emits b shifted right by one, with left_bit entering at the
// slice MSB (the next slice's LSB, or the fill bit on the last slice).
module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic             carry_disable,
    input  logic             left_bit,
    input  alu_cmd_t         cmd,
    output logic [SLICE-1:0] ret,
    output logic             cout
);

    logic [SLICE:0] sum;

    // Full add of the slice; SUB arrives here with b already inverted and a
    // carry of 1 on the first slice, so the same adder serves both.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + (SLICE + 1)'(cin);
    end

    // Select the slice result: shift path, carry-free XOR, or the adder.
    always_comb begin
        ret  = '0;
        cout = 1'b0;
        if (cmd == SHR) begin
            if (SLICE > 1) begin
                ret = b >> 1;
            end
            ret[SLICE-1] = left_bit;
            cout         = 1'b0;
        end else if (carry_disable) begin
            ret  = a ^ b;
            cout = 1'b0;
        end else begin
            ret  = sum[SLICE-1:0];
            cout = sum[SLICE];
        end
    end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU: accepts WIDTH-bit operands through a valid/ready handshake
// and walks them LSB-first, one SLICE-bit slice per clock, through a single
// alu_slice. The carry is registered between slices. The result is held with
// out_valid until the consumer takes it.
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  alu_cmd_t         cmd,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry_out,
    output logic             zero
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IW  = idx_width(NSL);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    if (WIDTH % SLICE != 0) begin : g_width_check
        $error("alu_serial: WIDTH must be a multiple of SLICE");
    end
    if (NSL < 1) begin : g_nsl_check
        $error("alu_serial: SLICE must not exceed WIDTH");
    end

    alu_state_t       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] d1_q;
    logic [WIDTH-1:0] d2_q;
    alu_cmd_t         cmd_q;
    logic             carry_q;
    logic             fill_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q;
    logic             zero_q;

    logic [31:0]      base;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_raw;
    logic [SLICE-1:0] b_s;
    logic [WIDTH:0]   d2_ext;
    logic [WIDTH:0]   left_vec;
    logic             left_bit;
    logic             carry_disable;
    logic [SLICE-1:0] slice_ret;
    logic             slice_cout;
    logic             last;
    logic [WIDTH-1:0] res_next;
    logic             final_cout;
    logic             accept;

    assign accept = in_valid && (state == IDLE);

    // Pick the current slice of each operand and the bit that shifts into its
    // MSB; appending the fill bit above d2 makes the last slice fall out of the
    // same shift as the others.
    always_comb begin
        base          = 32'(idx) * 32'(SLICE);
        a_s           = SLICE'(d1_q >> base);
        b_raw         = SLICE'(d2_q >> base);
        b_s           = (cmd_q == SUB) ? ~b_raw : b_raw;
        d2_ext        = {fill_q, d2_q};
        left_vec      = d2_ext >> (base + 32'(SLICE));
        left_bit      = left_vec[0];
        carry_disable = (cmd_q == XOR);
        last          = (idx == IW'(NSL - 1));
    end

    alu_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a            (a_s),
        .b            (b_s),
        .cin          (carry_q),
        .carry_disable(carry_disable),
        .left_bit     (left_bit),
        .cmd          (cmd_q),
        .ret          (slice_ret),
        .cout         (slice_cout)
    );

    // Merge the slice output into the result word and work out the carry flag
    // that is published once the final slice has been processed.
    always_comb begin
        res_next = (res_q & ~(SLICE_MASK << base)) | (WIDTH'(slice_ret) << base);
        case (cmd_q)
            ADD, SUB: final_cout = slice_cout;
            SHR:      final_cout = d2_q[0];
            default:  final_cout = 1'b0;
        endcase
    end

    // Control FSM and slice index: IDLE until a handshake, one RUN cycle per
    // slice, then DONE until the consumer takes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (accept) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand capture on accept, plus the inter-slice carry: ADD starts from
    // carry_in, SUB from 1 (two's complement), XOR/SHR from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1_q    <= '0;
            d2_q    <= '0;
            cmd_q   <= ADD;
            carry_q <= 1'b0;
            fill_q  <= 1'b0;
        end else if (accept) begin
            d1_q   <= d1;
            d2_q   <= d2;
            cmd_q  <= cmd;
            fill_q <= carry_in;
            case (cmd)
                ADD:     carry_q <= carry_in;
                SUB:     carry_q <= 1'b1;
                default: carry_q <= 1'b0;
            endcase
        end else if (state == RUN && (cmd_q == ADD || cmd_q == SUB)) begin
            carry_q <= slice_cout;
        end
    end

    // Result word and flags: the word fills slice by slice, and the flags are
    // captured on the last RUN edge so they appear together with out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == RUN) begin
            res_q <= res_next;
            if (last) begin
                cout_q <= final_cout;
                zero_q <= (res_next == '0);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign res       = res_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: three instances (16/4, 8/8, 32/4) share the clock,
// reset and operand buses, each with its own handshake. Results are compared
// with an arithmetic reference model.
module tb_alu_serial;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [31:0] d1_v;
    logic [31:0] d2_v;
    alu_cmd_t    cmd_v;
    logic        cin_v;

    wire [2:0]  in_ready_w;
    wire [2:0]  out_valid_w;
    wire [2:0]  carry_w;
    wire [2:0]  zero_w;
    wire [15:0] res0;
    wire [7:0]  res1;
    wire [31:0] res2;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_serial #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
        .d1(d1_v[15:0]), .d2(d2_v[15:0]), .cmd(cmd_v), .carry_in(cin_v),
        .out_valid(out_valid_w[0]), .out_ready(out_ready[0]), .res(res0),
        .carry_out(carry_w[0]), .zero(zero_w[0])
    );

    alu_serial #(.WIDTH(8), .SLICE(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
        .d1(d1_v[7:0]), .d2(d2_v[7:0]), .cmd(cmd_v), .carry_in(cin_v),
        .out_valid(out_valid_w[1]), .out_ready(out_ready[1]), .res(res1),
        .carry_out(carry_w[1]), .zero(zero_w[1])
    );

    alu_serial #(.WIDTH(32), .SLICE(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
        .d1(d1_v), .d2(d2_v), .cmd(cmd_v), .carry_in(cin_v),
        .out_valid(out_valid_w[2]), .out_ready(out_ready[2]), .res(res2),
        .carry_out(carry_w[2]), .zero(zero_w[2])
    );

    // Single comparison point: counts and reports every check.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int width_of(input int k);
        case (k)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int nsl_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] get_res(input int k);
        case (k)
            0:       return {16'h0, res0};
            1:       return {24'h0, res1};
            default: return res2;
        endcase
    endfunction

    // Reference model straight from the command definitions.
    task automatic model_op(input int w, input alu_cmd_t c, input logic [31:0] a,
                            input logic [31:0] b, input logic ci,
                            output logic [31:0] r, output logic co);
        logic [63:0] mask;
        logic [63:0] s;
        mask = (64'd1 << w) - 64'd1;
        s    = 64'd0;
        r    = 32'd0;
        co   = 1'b0;
        case (c)
            ADD: begin
                s  = {32'd0, a} + {32'd0, b} + {63'd0, ci};
                r  = 32'(s & mask);
                co = ((s >> w) & 64'd1) != 64'd0;
            end
            SUB: begin
                s  = {32'd0, a} - {32'd0, b};
                r  = 32'(s & mask);
                co = (a >= b);
            end
            XOR: begin
                r  = a ^ b;
                co = 1'b0;
            end
            default: begin
                r  = (b >> 1) | (32'(ci) << (w - 1));
                co = b[0];
            end
        endcase
    endtask

    // One full transaction on instance k: accept, wait for out_valid while
    // checking latency, hold under backpressure, then release. With noise set,
    // in_valid and the operand buses are scrambled while the op is in flight.
    task automatic apply_stimulus(input int k, input alu_cmd_t c, input logic [31:0] a_in,
                                  input logic [31:0] b_in, input logic ci,
                                  input int hold, input bit noise,
                                  output logic [31:0] obs_res, output logic obs_cout);
        int          w;
        int          lat;
        logic [31:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_cout;
        w    = width_of(k);
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        model_op(w, c, a, b, ci, exp_res, exp_cout);

        check_output("in_ready_idle", 32'(in_ready_w[k]), 32'd1);
        d1_v        = a;
        d2_v        = b;
        cmd_v       = c;
        cin_v       = ci;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;

        lat = 0;
        while (!out_valid_w[k] && lat < 40) begin
            check_output("in_ready_busy", 32'(in_ready_w[k]), 32'd0);
            if (noise) begin
                d1_v        = $urandom;
                d2_v        = $urandom;
                cmd_v       = alu_cmd_t'(2'($urandom_range(0, 3)));
                cin_v       = 1'($urandom_range(0, 1));
                in_valid[k] = 1'b1;
            end
            @(posedge clk); #1;
            in_valid[k] = 1'b0;
            lat++;
        end
        check_output("latency", 32'(lat), 32'(nsl_of(k)));
        check_output("res", get_res(k), exp_res);
        check_output("carry_out", 32'(carry_w[k]), 32'(exp_cout));
        check_output("zero", 32'(zero_w[k]), 32'(exp_res == 32'd0));
        obs_res  = get_res(k);
        obs_cout = carry_w[k];

        repeat (hold) begin
            in_valid[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            d1_v        = $urandom;
            @(posedge clk); #1;
            check_output("hold_valid", 32'(out_valid_w[k]), 32'd1);
            check_output("hold_in_ready", 32'(in_ready_w[k]), 32'd0);
            check_output("hold_res", get_res(k), exp_res);
            check_output("hold_carry", 32'(carry_w[k]), 32'(exp_cout));
            check_output("hold_zero", 32'(zero_w[k]), 32'(exp_res == 32'd0));
        end
        in_valid[k] = 1'b0;

        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check_output("release_valid", 32'(out_valid_w[k]), 32'd0);
        check_output("release_ready", 32'(in_ready_w[k]), 32'd1);
    endtask

    logic [31:0] r_obs;
    logic        c_obs;

    // Directed corner cases on the 16-bit instance, a mid-run reset, then
    // randomized traffic on all three instances.
    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        d1_v      = '0;
        d2_v      = '0;
        cmd_v     = ADD;
        cin_v     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check_output("rst_in_ready", 32'(in_ready_w), 32'h7);
        check_output("rst_out_valid", 32'(out_valid_w), 32'h0);
        check_output("rst_res", get_res(0), 32'h0);
        check_output("rst_carry", 32'(carry_w), 32'h0);
        check_output("rst_zero", 32'(zero_w), 32'h0);

        apply_stimulus(0, ADD, 32'hFFFF, 32'h0001, 1'b0, 0, 1'b0, r_obs, c_obs);
        check_output("t1_res", r_obs, 32'h0000);
        check_output("t1_cout", 32'(c_obs), 32'd1);
        apply_stimulus(0, SUB, 32'h0005, 32'h0007, 1'b0, 1, 1'b0, r_obs, c_obs);
        check_output("t2a_res", r_obs, 32'hFFFE);
        check_output("t2a_cout", 32'(c_obs), 32'd0);
        apply_stimulus(0, SUB, 32'h1234, 32'h1234, 1'b0, 0, 1'b0, r_obs, c_obs);
        check_output("t2b_res", r_obs, 32'h0000);
        check_output("t2b_cout", 32'(c_obs), 32'd1);
        apply_stimulus(0, SHR, 32'h0000, 32'h8001, 1'b1, 0, 1'b0, r_obs, c_obs);
        check_output("t3a_res", r_obs, 32'hC000);
        check_output("t3a_cout", 32'(c_obs), 32'd1);
        apply_stimulus(0, XOR, 32'hA5A5, 32'hFFFF, 1'b1, 0, 1'b0, r_obs, c_obs);
        check_output("t3b_res", r_obs, 32'h5A5A);
        check_output("t3b_cout", 32'(c_obs), 32'd0);
        apply_stimulus(0, ADD, 32'h1357, 32'h2468, 1'b1, 10, 1'b1, r_obs, c_obs);
        check_output("t4_res", r_obs, 32'h37C0);

        d1_v        = 32'h0000_1111;
        d2_v        = 32'h0000_2222;
        cmd_v       = ADD;
        cin_v       = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("t5_in_ready", 32'(in_ready_w[0]), 32'd1);
        check_output("t5_out_valid", 32'(out_valid_w[0]), 32'd0);
        check_output("t5_res", get_res(0), 32'h0);
        apply_stimulus(0, SUB, 32'h8000, 32'h0001, 1'b0, 0, 1'b0, r_obs, c_obs);
        check_output("t5_after_res", r_obs, 32'h7FFF);

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 25; n++) begin
                apply_stimulus(k, alu_cmd_t'(2'($urandom_range(0, 3))), $urandom, $urandom,
                               1'($urandom_range(0, 1)), $urandom_range(0, 3),
                               1'($urandom_range(0, 1)), r_obs, c_obs);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
